mips_debug_ctrl: RTL and testbench

- UART-driven debug controller for the MIPS pipeline.
- Receives a program over serial (8N1) and writes it word by word into instruction memory.
- Starts the pipeline in continuous or single-step mode.
- On halt, or after each step, dumps PC, cycle count, all 32 registers and the dirty data-memory words back over serial.
- Contains its own UART RX/TX with a 16x oversampling baud generator.

---
 rtl/mips_debug_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_ctrl.sv
// UART-driven debug controller for a MIPS pipeline.
// Loads a program over serial into instruction memory, starts the pipeline in continuous
// or single-step mode, then dumps PC, cycle count, the register file and the dirty
// data-memory words back over serial. Contains its own 8N1 UART with a 16x baud tick.
// Ports:
//   i_clock, i_reset (sync, active-low), i_halt, i_rx_data       : control / serial in
//   i_send_program_counter, i_cant_cycles                          : status to report
//   i_reg_debug_unit, i_bit_sucio, i_mem_debug_unit                : readout data (1-cycle)
//   o_addr_reg_debug_unit, o_addr_mem_debug_unit, o_ctrl_*         : readout control
//   o_tx_data                                                      : serial out
//   o_en_write, o_en_read, o_enable_pipe, o_enable_mem             : pipeline/memory enables
//   o_debug_unit_reg, o_inst_load, o_address                       : instruction-memory load
//   o_state                                                        : one-hot FSM state
module mips_debug_ctrl #(
  parameter int unsigned BAUD_RATE = 19200,
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_REG    = 5,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned NB_STATE  = 14
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_halt,
  input  logic                i_rx_data,
  input  logic [ADDR_W-1:0]   i_send_program_counter,
  input  logic [ADDR_W-1:0]   i_cant_cycles,
  input  logic [NB_DATA-1:0]  i_reg_debug_unit,
  input  logic                i_bit_sucio,
  input  logic [NB_DATA-1:0]  i_mem_debug_unit,
  output logic [NB_REG-1:0]   o_addr_reg_debug_unit,
  output logic [ADDR_W-1:0]   o_addr_mem_debug_unit,
  output logic                o_ctrl_addr_debug_mem,
  output logic                o_ctrl_wr_debug_mem,
  output logic                o_ctrl_read_debug_reg,
  output logic                o_tx_data,
  output logic                o_en_write,
  output logic                o_en_read,
  output logic                o_enable_pipe,
  output logic                o_enable_mem,
  output logic                o_debug_unit_reg,
  output logic [NB_DATA-1:0]  o_inst_load,
  output logic [ADDR_W-1:0]   o_address,
  output logic [NB_STATE-1:0] o_state
);

  localparam int unsigned Div  = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int unsigned DivW = $clog2(Div + 1);

  typedef enum logic [13:0] {
    StIdle = 14'h0001, StRxCount = 14'h0002, StRxInst = 14'h0004, StWriteInst = 14'h0008,
    StWaitMode = 14'h0010, StRun = 14'h0020, StStepWait = 14'h0040, StStepExec = 14'h0080,
    StSendPc = 14'h0100, StSendCycles = 14'h0200, StReadReg = 14'h0400,
    StSendReg = 14'h0800, StReadMem = 14'h1000, StSendMem = 14'h2000
  } state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_st_e;

  // UART state
  logic [DivW-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [1:0]      rx_sync_q, rx_sync_d;
  logic            rx_in;
  rx_st_e          rx_st_q, rx_st_d;
  logic [3:0]      rx_tick_q, rx_tick_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_done_q, rx_done_d;
  tx_st_e          tx_st_q, tx_st_d;
  logic [3:0]      tx_tick_q, tx_tick_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_start;
  logic [7:0]      tx_byte;

  // Controller state
  state_e            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] inst_q, inst_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic [NB_REG-1:0] reg_idx_q, reg_idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              dbg_q, dbg_d;
  logic              busy_q, busy_d;       // a byte has been handed to TX and is in flight
  logic              from_step_q, from_step_d;
  logic              term_q, term_d;       // memory scan finished, 0xFF terminator pending
  logic              en_pipe, dbg_mem;
  logic [NB_DATA-1:0] sel_word;
  logic [1:0]        mem_idx;

  assign tick  = (tick_cnt_q == DivW'(Div - 1));
  assign rx_in = rx_sync_q[1];

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + DivW'(1);
    rx_sync_d  = {rx_sync_q[0], i_rx_data};
    rx_st_d    = rx_st_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_d  = 1'b0;
    unique case (rx_st_q)
      RxIdle: if (!rx_in) begin
        rx_st_d   = RxStart;
        rx_tick_d = '0;
      end
      // Any high sample before the 8th tick rejects the start bit as a glitch.
      RxStart: if (rx_in) begin
        rx_st_d = RxIdle;
      end else if (tick) begin
        if (rx_tick_q == 4'd7) begin
          rx_st_d   = RxData;
          rx_tick_d = '0;
          rx_bit_d  = '0;
        end else begin
          rx_tick_d = rx_tick_q + 4'd1;
        end
      end
      RxData: if (tick) begin
        if (rx_tick_q == 4'd15) begin
          rx_tick_d  = '0;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RxStop;
        end else begin
          rx_tick_d = rx_tick_q + 4'd1;
        end
      end
      RxStop: if (tick) begin
        if (rx_tick_q == 4'd15) begin
          rx_st_d   = RxIdle;
          rx_done_d = 1'b1;
        end else begin
          rx_tick_d = rx_tick_q + 4'd1;
        end
      end
      default: rx_st_d = RxIdle;
    endcase

    tx_st_d    = tx_st_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    unique case (tx_st_q)
      TxIdle: if (tx_start) begin
        tx_st_d    = TxStart;
        tx_shift_d = tx_byte;
        tx_tick_d  = '0;
      end
      TxStart, TxData, TxStop: if (tick) begin
        if (tx_tick_q == 4'd15) begin
          tx_tick_d = '0;
          if (tx_st_q == TxStart) begin
            tx_st_d  = TxData;
            tx_bit_d = '0;
          end else if (tx_st_q == TxData) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_st_d = TxStop;
          end else begin
            tx_st_d   = TxIdle;
            tx_done_d = 1'b1;
          end
        end else begin
          tx_tick_d = tx_tick_q + 4'd1;
        end
      end
      default: tx_st_d = TxIdle;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    inst_d      = inst_q;
    word_d      = word_q;
    reg_idx_d   = reg_idx_q;
    mem_addr_d  = mem_addr_q;
    dbg_d       = dbg_q;
    from_step_d = from_step_q;
    term_d      = term_q;
    tx_start    = 1'b0;
    tx_byte     = '0;
    en_pipe     = 1'b0;
    dbg_mem     = 1'b0;
    o_en_write  = 1'b0;
    o_ctrl_read_debug_reg = 1'b0;
    sel_word    = word_q;
    mem_idx     = 2'(byte_cnt_q - 3'd1);
    unique case (state_q)
      StIdle: begin
        state_d    = StRxCount;
        addr_d     = '0;
        word_cnt_d = '0;
        byte_cnt_d = '0;
        dbg_d      = 1'b0;
      end
      StRxCount: if (rx_done_q) begin
        count_d    = rx_shift_q;
        word_cnt_d = '0;
        addr_d     = '0;
        byte_cnt_d = '0;
        if (rx_shift_q == 8'h00) begin
          state_d = StWaitMode;
        end else begin
          state_d = StRxInst;
          dbg_d   = 1'b1;
        end
      end
      StRxInst: if (rx_done_q) begin
        inst_d     = {inst_q[NB_DATA-9:0], rx_shift_q};
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'd3) state_d = StWriteInst;
      end
      StWriteInst: begin
        o_en_write = 1'b1;
        addr_d     = addr_q + ADDR_W'(1);
        word_cnt_d = word_cnt_q + 8'd1;
        byte_cnt_d = '0;
        if (word_cnt_q + 8'd1 == count_q) begin
          state_d = StWaitMode;
          dbg_d   = 1'b0;
        end else begin
          state_d = StRxInst;
        end
      end
      StWaitMode: if (rx_done_q) begin
        if (rx_shift_q == 8'h10) begin
          state_d     = StRun;
          from_step_d = 1'b0;
        end else if (rx_shift_q == 8'h20) begin
          state_d = StStepWait;
        end
      end
      StRun: begin
        en_pipe = 1'b1;
        if (i_halt) state_d = StSendPc;
      end
      StStepWait: begin
        if (i_halt) begin
          state_d     = StSendPc;
          from_step_d = 1'b0;
        end else if (rx_done_q && rx_shift_q == 8'h30) begin
          state_d = StStepExec;
        end else if (rx_done_q && rx_shift_q == 8'h40) begin
          state_d = StIdle;
        end
      end
      StStepExec: begin
        en_pipe     = 1'b1;
        from_step_d = 1'b1;
        state_d     = StSendPc;
      end
      StSendPc, StSendCycles: begin
        tx_byte  = (state_q == StSendPc) ? 8'(i_send_program_counter) : 8'(i_cant_cycles);
        tx_start = !busy_q;
        if (tx_done_q) begin
          byte_cnt_d = '0;
          reg_idx_d  = '0;
          state_d    = (state_q == StSendPc) ? StSendCycles : StReadReg;
        end
      end
      StReadReg: begin
        o_ctrl_read_debug_reg = 1'b1;
        state_d = StSendReg;
      end
      StSendReg: begin
        o_ctrl_read_debug_reg = 1'b1;
        // Byte 0 goes out straight from the read port; the word is latched for bytes 1..3.
        sel_word = (byte_cnt_q == 3'd0) ? i_reg_debug_unit : word_q;
        tx_byte  = 8'(sel_word >> {~byte_cnt_q[1:0], 3'b000});
        tx_start = !busy_q;
        if (!busy_q && byte_cnt_q == 3'd0) word_d = i_reg_debug_unit;
        if (tx_done_q) begin
          if (byte_cnt_q == 3'd3) begin
            byte_cnt_d = '0;
            if (reg_idx_q == '1) begin
              state_d    = StReadMem;
              mem_addr_d = '0;
              term_d     = 1'b0;
            end else begin
              reg_idx_d = reg_idx_q + NB_REG'(1);
              state_d   = StReadReg;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      StReadMem: begin
        dbg_mem = 1'b1;
        state_d = StSendMem;
      end
      StSendMem: begin
        dbg_mem = 1'b1;
        if (term_q) begin
          tx_byte  = 8'hFF;
          tx_start = !busy_q;
          if (tx_done_q) begin
            term_d  = 1'b0;
            state_d = from_step_q ? StStepWait : StIdle;
          end
        end else if (byte_cnt_q == 3'd0 && !busy_q && !i_bit_sucio) begin
          // Clean word: skip straight to the next address.
          if (mem_addr_q == '1) begin
            term_d = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = StReadMem;
          end
        end else begin
          // Dirty word: address byte, then 4 data bytes MSB first.
          tx_byte  = (byte_cnt_q == 3'd0) ? 8'(mem_addr_q)
                                          : 8'(word_q >> {~mem_idx, 3'b000});
          tx_start = !busy_q;
          if (!busy_q && byte_cnt_q == 3'd0) word_d = i_mem_debug_unit;
          if (tx_done_q) begin
            if (byte_cnt_q == 3'd4) begin
              byte_cnt_d = '0;
              if (mem_addr_q == '1) begin
                term_d = 1'b1;
              end else begin
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                state_d    = StReadMem;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = tx_start ? 1'b1 : (tx_done_q ? 1'b0 : busy_q);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      tick_cnt_q <= '0;
      rx_sync_q  <= 2'b11;
      rx_st_q    <= RxIdle;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_done_q  <= 1'b0;
      tx_st_q    <= TxIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_done_q  <= 1'b0;
      state_q    <= StIdle;
      count_q    <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      inst_q     <= '0;
      word_q     <= '0;
      reg_idx_q  <= '0;
      mem_addr_q <= '0;
      dbg_q      <= 1'b0;
      busy_q     <= 1'b0;
      from_step_q <= 1'b0;
      term_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rx_sync_q  <= rx_sync_d;
      rx_st_q    <= rx_st_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_done_q  <= rx_done_d;
      tx_st_q    <= tx_st_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
      state_q    <= state_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      word_q     <= word_d;
      reg_idx_q  <= reg_idx_d;
      mem_addr_q <= mem_addr_d;
      dbg_q      <= dbg_d;
      busy_q     <= busy_d;
      from_step_q <= from_step_d;
      term_q     <= term_d;
    end
  end

  assign o_tx_data             = (tx_st_q == TxStart) ? 1'b0 :
                                 (tx_st_q == TxData)  ? tx_shift_q[0] : 1'b1;
  assign o_enable_pipe         = en_pipe;
  assign o_enable_mem          = en_pipe;
  assign o_en_read             = en_pipe;
  assign o_ctrl_addr_debug_mem = dbg_mem;
  assign o_ctrl_wr_debug_mem   = dbg_mem;
  assign o_addr_reg_debug_unit = reg_idx_q;
  assign o_addr_mem_debug_unit = mem_addr_q;
  assign o_debug_unit_reg      = dbg_q;
  assign o_inst_load           = inst_q;
  assign o_address             = addr_q;
  assign o_state               = NB_STATE'(state_q);

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Bench for mips_debug_ctrl: directed serial stimulus, a byte-level dump model built from
// the bench's register/memory arrays, and monitors that decode the serial output and the
// instruction-memory write strobe.
module tb_mips_debug_ctrl;
  localparam int unsigned Baud = 19200;
  localparam int unsigned Clk  = 16 * Baud;  // one oversampling tick per clock
  localparam int unsigned Aw   = 4;

  localparam logic [13:0] SIdle = 14'h0001, SRxCount = 14'h0002, SRxInst = 14'h0004;
  localparam logic [13:0] SWaitMode = 14'h0010, SRun = 14'h0020, SStepWait = 14'h0040;
  localparam logic [13:0] SSendPc = 14'h0100;

  logic clk = 1'b0;
  logic rst_n, halt, rx, dirty_bit;
  logic [Aw-1:0] pc, cyc;
  logic [31:0] reg_rd, mem_rd;
  logic [4:0] o_addr_reg;
  logic [Aw-1:0] o_addr_mem, o_address;
  logic o_ctrl_addr, o_ctrl_wr, o_ctrl_read, o_tx_data, o_en_write, o_en_read;
  logic o_enable_pipe, o_enable_mem, o_debug_unit_reg;
  logic [31:0] o_inst_load;
  logic [13:0] o_state;

  always #5 clk = ~clk;

  mips_debug_ctrl #(.BAUD_RATE(Baud), .CLK_FREQ(Clk), .NB_DATA(32), .NB_REG(5),
                    .ADDR_W(Aw), .NB_STATE(14)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_halt(halt), .i_rx_data(rx),
    .i_send_program_counter(pc), .i_cant_cycles(cyc), .i_reg_debug_unit(reg_rd),
    .i_bit_sucio(dirty_bit), .i_mem_debug_unit(mem_rd),
    .o_addr_reg_debug_unit(o_addr_reg), .o_addr_mem_debug_unit(o_addr_mem),
    .o_ctrl_addr_debug_mem(o_ctrl_addr), .o_ctrl_wr_debug_mem(o_ctrl_wr),
    .o_ctrl_read_debug_reg(o_ctrl_read), .o_tx_data(o_tx_data), .o_en_write(o_en_write),
    .o_en_read(o_en_read), .o_enable_pipe(o_enable_pipe), .o_enable_mem(o_enable_mem),
    .o_debug_unit_reg(o_debug_unit_reg), .o_inst_load(o_inst_load), .o_address(o_address),
    .o_state(o_state)
  );

  // Register file and data memory seen by the controller, 1-cycle read latency.
  logic [31:0] regs [32];
  logic [31:0] mem [16];
  logic        dirty [16];
  always @(posedge clk) begin
    reg_rd <= regs[o_addr_reg];
    mem_rd <= mem[o_addr_mem];
  end
  assign dirty_bit = dirty[o_addr_mem];

  logic [7:0]    exp_tx [$];
  logic [31:0]   exp_wr_data [$];
  logic [Aw-1:0] exp_wr_addr [$];
  int checks = 0, passes = 0, tx_bytes = 0, wr_count = 0, en_cycles = 0;
  int b0, e0, w0;
  logic [7:0] last_tx = 8'h00, mon_b;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected dump: PC, cycles, 32 registers MSB first, dirty words as addr+4 bytes, 0xFF.
  task automatic push_dump(input logic [7:0] p, input logic [7:0] c);
    exp_tx.push_back(p);
    exp_tx.push_back(c);
    for (int r = 0; r < 32; r++)
      for (int k = 3; k >= 0; k--) exp_tx.push_back(regs[r][8*k +: 8]);
    for (int a = 0; a < 16; a++)
      if (dirty[a]) begin
        exp_tx.push_back(8'(a));
        for (int k = 3; k >= 0; k--) exp_tx.push_back(mem[a][8*k +: 8]);
      end
    exp_tx.push_back(8'hFF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_state(input string name, input logic [13:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_state == s) break;
      @(negedge clk);
    end
    chk(name, o_state, s);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_tx.size() == 0) break;
      @(negedge clk);
    end
    chk(name, exp_tx.size(), 0);
  endtask

  // Serial output decoder: sample each bit at its middle, compare with the dump model.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge o_tx_data);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        mon_b[i] = o_tx_data;
      end
      repeat (16) @(negedge clk);
      chk("tx_stop_bit", o_tx_data, 1);
      tx_bytes++;
      last_tx = mon_b;
      if (exp_tx.size() == 0) begin
        checks++;
        $display("FAIL tx_unexpected: got 0x%0h, expected no byte", mon_b);
      end else begin
        chk("tx_byte", mon_b, exp_tx.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (o_enable_pipe) en_cycles++;
    if (o_en_write) begin
      wr_count++;
      if (exp_wr_data.size() == 0) begin
        checks++;
        $display("FAIL wr_unexpected: got 0x%0h at %0d, expected no write",
                 o_inst_load, o_address);
      end else begin
        chk("wr_data", o_inst_load, exp_wr_data.pop_front());
        chk("wr_addr", o_address, exp_wr_addr.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; halt = 1'b0; rx = 1'b1; pc = 4'd3; cyc = 4'd4;
    for (int r = 0; r < 32; r++) regs[r] = {8'(r), 8'(r) ^ 8'hA5, 8'(3 * r), 8'hC3 ^ 8'(r)};
    for (int a = 0; a < 16; a++) begin
      mem[a]   = 32'hDEAD_0000 | (32'(a) * 32'h111);
      dirty[a] = (a == 2) || (a == 9);
    end

    @(posedge clk);
    @(negedge clk);
    chk("rst_state", o_state, SIdle);
    chk("rst_ctrl", {o_en_write, o_en_read, o_enable_pipe, o_enable_mem, o_debug_unit_reg,
                     o_ctrl_addr, o_ctrl_wr, o_ctrl_read}, 0);
    chk("rst_tx", o_tx_data, 1);
    chk("rst_addr", o_address, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("state_rx_count", o_state, SRxCount);

    // Short low pulse must not be taken as a start bit (would read as count 0xFF).
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_rejected", o_state, SRxCount);

    // Two-word program load.
    exp_wr_data.push_back(32'h0203_0405); exp_wr_addr.push_back(4'd0);
    exp_wr_data.push_back(32'h0607_0809); exp_wr_addr.push_back(4'd1);
    send_byte(8'h02);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    chk("dbg_during_load", o_debug_unit_reg, 1);
    send_byte(8'h06); send_byte(8'h07); send_byte(8'h08); send_byte(8'h09);
    wait_state("load_done", SWaitMode, 200);
    chk("dbg_after_load", o_debug_unit_reg, 0);
    chk("two_writes", wr_count, 2);
    chk("addr_after_load", o_address, 2);

    // Unknown mode byte and stray halt are ignored.
    send_byte(8'h55);
    repeat (20) @(negedge clk);
    chk("wait_mode_ignores_55", o_state, SWaitMode);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    @(negedge clk);
    chk("halt_ignored", o_state, SWaitMode);

    // Continuous run, halt, full dump (2 + 128 + 2*5 + 1 = 141 bytes).
    push_dump(8'h03, 8'h04);
    b0 = tx_bytes;
    send_byte(8'h10);
    wait_state("run", SRun, 100);
    repeat (5) @(negedge clk);
    chk("enables_in_run", {o_enable_pipe, o_enable_mem, o_en_read}, 3'b111);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_to_send_pc", o_state, SSendPc);
    chk("enables_off", {o_enable_pipe, o_enable_mem, o_en_read}, 0);
    wait_drain("run_dump_drained", 30000);
    wait_state("run_dump_to_idle", SRxCount, 1000);
    chk("run_dump_bytes", tx_bytes - b0, 141);
    chk("run_dump_last", last_tx, 8'hFF);

    // Zero-length program, then single step (2 + 128 + 5 + 1 = 136 bytes).
    w0 = wr_count;
    send_byte(8'h00);
    wait_state("n0_wait_mode", SWaitMode, 100);
    chk("n0_no_write", wr_count - w0, 0);
    send_byte(8'h20);
    wait_state("step_wait", SStepWait, 100);
    dirty[2] = 1'b0; dirty[9] = 1'b0; dirty[15] = 1'b1;
    pc = 4'd5; cyc = 4'd1;
    push_dump(8'h05, 8'h01);
    b0 = tx_bytes;
    e0 = en_cycles;
    send_byte(8'h30);
    wait_state("step_send_pc", SSendPc, 100);
    chk("step_pulse_width", en_cycles - e0, 1);
    wait_drain("step_dump_drained", 30000);
    wait_state("step_back_to_wait", SStepWait, 1000);
    chk("step_dump_bytes", tx_bytes - b0, 136);
    chk("step_dump_last", last_tx, 8'hFF);
    send_byte(8'h40);
    wait_state("step_exit_idle", SRxCount, 100);

    // Reset in the middle of an instruction, then reload from address 0.
    w0 = wr_count;
    send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    chk("mid_rx_inst", o_state, SRxInst);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_idle", o_state, SIdle);
    rst_n = 1'b1;
    chk("mid_reset_no_write", wr_count - w0, 0);
    exp_wr_data.push_back(32'h1122_3344); exp_wr_addr.push_back(4'd0);
    send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_state("reload_wait_mode", SWaitMode, 200);
    chk("reload_one_write", wr_count - w0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
